// File: rtl/ap3_sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, programmable
// almost-empty/almost-full thresholds, sticky overflow/underflow and synchronous flush.
module ap3_sync_fifo #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned FWFT   = 0
) (
    input  logic              QCK,
    input  logic              QRT,
    input  logic              WEN,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic              REN,
    output logic [WIDTH-1:0]  RDATA,
    input  logic              FFLUSH,
    input  logic [ADDR_W-1:0] UPAE,
    input  logic [ADDR_W-1:0] UPAF,
    output logic [ADDR_W:0]   COUNT,
    output logic [3:0]        FFLAGS,
    output logic              OVF,
    output logic              UDF
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0]  mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [WIDTH-1:0]  rdata_q;
    logic [WIDTH-1:0]  head;
    logic              ovf_q, udf_q;
    logic              full, empty, afull, aempty;
    logic              wr_acc, rd_acc;

    always_comb begin
        full   = (count == DEPTH_C);
        empty  = (count == '0);
        aempty = (count <= {1'b0, UPAE});
        // UPAF < DEPTH always, so the subtraction cannot wrap
        afull  = (count >= (DEPTH_C - {1'b0, UPAF}));
        wr_acc = WEN & ~full & ~FFLUSH;
        rd_acc = REN & ~empty & ~FFLUSH;
        head   = mem[rd_ptr];
    end

    always_ff @(posedge QCK) begin
        if (wr_acc)
            mem[wr_ptr] <= WDATA;
    end

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (FFLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (WEN && full)
                ovf_q <= 1'b1;
            if (REN && empty)
                udf_q <= 1'b1;
        end
    end

    // In FWFT mode rdata_q tracks the displayed head so it can be held once empty
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT)
            rdata_q <= '0;
        else if (FWFT != 0) begin
            if (!empty)
                rdata_q <= head;
        end else if (rd_acc)
            rdata_q <= head;
    end

    assign RDATA  = ((FWFT != 0) && !empty) ? head : rdata_q;
    assign COUNT  = count;
    assign FFLAGS = {full, afull, aempty, empty};
    assign OVF    = ovf_q;
    assign UDF    = udf_q;

endmodule

// File: tb/tb_ap3_sync_fifo.sv
// Self-checking bench: registered and FWFT instances share stimulus and are checked
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_ap3_sync_fifo;

    logic       qck = 1'b0;
    logic       qrt;
    logic       wen, ren, fflush;
    logic [7:0] wdata;
    logic [3:0] upae, upaf;
    logic [7:0] rdata0, rdata1;
    logic [4:0] count0, count1;
    logic [3:0] fflags0, fflags1;
    logic       ovf0, udf0, ovf1, udf1;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0] q[$];
    logic       m_ovf, m_udf;
    logic [7:0] m_rd0, m_hold1;

    always #5 qck = ~qck;

    ap3_sync_fifo #(.WIDTH(8), .ADDR_W(4), .FWFT(0)) dut0 (
        .QCK(qck), .QRT(qrt), .WEN(wen), .WDATA(wdata), .REN(ren), .RDATA(rdata0),
        .FFLUSH(fflush), .UPAE(upae), .UPAF(upaf), .COUNT(count0), .FFLAGS(fflags0),
        .OVF(ovf0), .UDF(udf0)
    );

    ap3_sync_fifo #(.WIDTH(8), .ADDR_W(4), .FWFT(1)) dut1 (
        .QCK(qck), .QRT(qrt), .WEN(wen), .WDATA(wdata), .REN(ren), .RDATA(rdata1),
        .FFLUSH(fflush), .UPAE(upae), .UPAF(upaf), .COUNT(count1), .FFLAGS(fflags1),
        .OVF(ovf1), .UDF(udf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_flags();
        int unsigned n;
        n = q.size();
        return {n == 16, (16 - n) <= upaf, n <= upae, n == 0};
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] e1;
        e1 = (q.size() != 0) ? q[0] : m_hold1;
        chk({tag, ".count0"}, count0, q.size());
        chk({tag, ".count1"}, count1, q.size());
        chk({tag, ".flags0"}, fflags0, exp_flags());
        chk({tag, ".flags1"}, fflags1, exp_flags());
        chk({tag, ".ovf"}, {ovf0, ovf1}, {m_ovf, m_ovf});
        chk({tag, ".udf"}, {udf0, udf1}, {m_udf, m_udf});
        chk({tag, ".rdata0"}, rdata0, m_rd0);
        chk({tag, ".rdata1"}, rdata1, e1);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_rd0 = 8'h00; m_hold1 = 8'h00;
    endtask

    // Next state of the reference, computed from pre-edge state and current inputs
    task automatic model_edge();
        bit was_full, was_empty;
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (!was_empty) m_hold1 = q[0];
        if (fflush) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wen && was_full)  m_ovf = 1'b1;
            if (ren && was_empty) m_udf = 1'b1;
            if (ren && !was_empty) m_rd0 = q.pop_front();
            if (wen && !was_full) q.push_back(wdata);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input string tag);
        wen = w; wdata = d; ren = r; fflush = f;
        model_edge();
        @(posedge qck);
        #1;
        check_all(tag);
        wen = 1'b0; ren = 1'b0; fflush = 1'b0;
    endtask

    initial begin
        logic [7:0] seen;
        qrt = 1'b1; wen = 1'b1; ren = 1'b1; fflush = 1'b0; wdata = 8'h55;
        upae = 4'd2; upaf = 4'd2;
        model_reset();
        // requests during reset must be ignored
        repeat (2) @(posedge qck);
        #1;
        check_all("reset");
        chk("reset.flags_const", fflags0, 4'b0011);
        #2 qrt = 1'b0; wen = 1'b0; ren = 1'b0;
        @(posedge qck); #1;

        // fill and drain, with threshold sweep
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        chk("fill.count", count0, 5'd16);
        chk("fill.flags", fflags0, 4'b1100);
        step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
        chk("ovf.flag", ovf0, 1'b1);
        chk("ovf.count", count0, 5'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
            chk("drain.data", rdata0, 8'(i));
        end
        chk("drain.flags", fflags0, 4'b0011);
        step(1'b0, 8'h00, 1'b1, 1'b0, "udf");
        chk("udf.flag", udf0, 1'b1);
        chk("udf.rdata_hold", rdata0, 8'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1, "flush");
        chk("flush.sticky", {ovf0, udf0}, 2'b00);

        // simultaneous ops across the pointer wrap
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "sim_pre");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h45 + i), 1'b1, 1'b0, "sim");
            chk("sim.data", rdata0, 8'(8'h40 + i));
        end
        chk("sim.count", count0, 5'd5);
        for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "sim_fill");
        step(1'b1, 8'hEE, 1'b1, 1'b0, "full_rw");
        chk("full_rw.count", count0, 5'd15);

        // threshold change without an edge
        step(1'b0, 8'h00, 1'b0, 1'b1, "flush2");
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "ae_fill");
        chk("ae.before", fflags0[1], 1'b0);
        upae = 4'd5;
        #1;
        chk("ae.comb", fflags0[1], 1'b1);
        chk("ae.comb1", fflags1[1], 1'b1);
        upae = 4'd2;
        #1;

        // FWFT head visibility and hold
        step(1'b0, 8'h00, 1'b0, 1'b1, "flush3");
        step(1'b1, 8'h3C, 1'b0, 1'b0, "fwft_wr");
        chk("fwft.head", rdata1, 8'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_rd");
        chk("fwft.hold", rdata1, 8'h3C);
        chk("fwft.empty", fflags1[0], 1'b1);

        // asynchronous reset mid-operation
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_rst");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_rd");
        #2 qrt = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst.rdata", {rdata0, rdata1}, 16'h0000);
        #1 qrt = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0, "post_rst_wr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_rd");
        chk("post_rst.data", rdata0, 8'h5A);

        // randomized traffic including threshold changes and rare flushes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                upae = 4'($urandom_range(0, 15));
                upaf = 4'($urandom_range(0, 15));
            end
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
